serial_msg_endpoint: RTL and testbench
======================================

# serial_msg_endpoint

FPGA-side message endpoint for the 32-bit bramfeeder word channel of the ublaze serial device. The block drains the processor-to-FPGA word stream and parses it into framed messages for a client. It also frames client messages into the FPGA-to-processor word stream. It sits between the serial device's ppcMessageOutput/ppcMessageInput RDY/EN ports and LEAP channel logic.

## Interface
- No parameters. Word width is fixed at 32; length field 8 bits; channel field 8 bits.
- sys_clk_pin  in  1  sole clock; all logic is rising-edge.
- sys_rst_pin  in  1  asynchronous, active-high reset.
- RDY_ppcMessageOutput_get  in  1  feeder has a word for the FPGA.
- ppcMessageOutput_get  in  32  that word; valid while RDY is high.
- EN_ppcMessageOutput_get  out  1  consume the word this cycle.
- RDY_ppcMessageInput_put  in  1  feeder can accept a word.
- ppcMessageInput_put  out  32  word to the processor.
- EN_ppcMessageInput_put  out  1  write the word this cycle.
- rx_valid, rx_ready  out, in  1, 1  client receive handshake.
- rx_data  out  32  payload word.
- rx_chan  out  8  channel of the current message.
- rx_first, rx_last  out  1, 1  first and last payload word markers.
- tx_valid, tx_ready  in, out  1, 1  client transmit handshake.
- tx_data  in  32  payload word.
- tx_chan, tx_len  in  8, 8  sampled only on a message's header load.
- rx_err  out  1  sticky bad-header flag.
- rx_msg_count  out  16  completed RX messages; wraps at 65535 to 0.

## Operation
- Header word format: [31:16] = 16'hC0DE, [15:8] = channel, [7:0] = N payload words. N=0 encodes 256 words. Header words are never forwarded to the client.
- RX FSM has states R_HDR and R_PAY, with a 9-bit remaining counter and a 1-entry output register.
  - R_HDR: EN_get = RDY_get; every header is consumed.
    - Bad magic: discard the word, set rx_err, stay in R_HDR.
    - Good magic: latch channel, set remaining = N (256 if N=0), set first flag, go to R_PAY.
  - R_PAY: EN_get = RDY_get && (!rx_valid || rx_ready).
    - On consume: load the output register with data, rx_first = first flag, rx_last = (remaining==1); clear first flag; decrement remaining.
    - When the last word loads: go to R_HDR and increment rx_msg_count.
  - Output register: holds its value while rx_valid && !rx_ready; clears when drained with no new load.
- TX FSM has states T_IDLE and T_PAY, with a 9-bit remaining counter and a 1-entry output buffer (obuf).
  - Free condition: free = !obuf_v || RDY_put.
  - EN_put = obuf_v && RDY_put; ppcMessageInput_put = obuf data.
  - T_IDLE: tx_ready = 0. When tx_valid && free: load obuf with {16'hC0DE, tx_chan, tx_len}, set remaining from tx_len (0 = 256), go to T_PAY.
  - T_PAY: tx_ready = free. On accept: load obuf with tx_data and decrement remaining. After the last word is accepted, go to T_IDLE.
- rx_err is cleared only by reset.

## Timing
- Reset (asynchronous, immediate):
  - All state goes to R_HDR / T_IDLE; counters and remaining = 0.
  - rx_valid, rx_first, rx_last, rx_err = 0; rx_data = 0; rx_chan = 0.
  - tx_ready = 0; obuf_v = 0; ppcMessageInput_put = 0.
  - Both EN outputs are forced to 0 while sys_rst_pin is high.
- Reset mid-message: partial messages in either direction are lost. After release, RX expects a header.
- RX latency: a word consumed at edge t appears on rx_data after edge t. Sustained rate is 1 word/cycle with RDY_get and rx_ready high. Header cost: 1 cycle, no rx_valid.
- TX latency: header loads on the edge after tx_valid is seen in T_IDLE. Payload word k is accepted at the earliest 1 cycle after header load. A word accepted at edge t is offered on put from t+1.
- TX throughput: message of M words takes M+1 put cycles minimum. Back-to-back messages add no bubble; a T_IDLE header load overlaps with obuf drain.
- Simultaneous obuf drain and load in the same cycle is legal: EN_put takes the old word, and obuf takes the new one.
- Counter arithmetic is unsigned. rx_msg_count wraps modulo 2^16.
- RDY_get low mid-message stalls RX indefinitely. RDY_put low stalls TX, and tx_ready falls once obuf is full.

## Test plan
- RX basic: feed C0DE_0503 followed by A,B,C, with rx_ready=1.
  - Required: three rx_valid cycles, data A,B,C, rx_chan=5.
  - rx_first only on A; rx_last only on C.
  - rx_msg_count=1; first data one cycle after its EN_get.
- RX bad magic: feed 1234_0102 then C0DE_0101, D.
  - Required: rx_err=1; first word dropped; D delivered with first=last=1.
- RX backpressure: rx_ready=0 for 5 cycles mid-message.
  - Required: EN_get stays low while the output register is full; no word lost or duplicated.
- TX 256-word: tx_len=0, tx_chan=7, RDY_put=1.
  - Required: put stream C0DE_0700 then 256 payload words in order, then return to T_IDLE.
- TX stall and back-to-back: two 2-word messages with RDY_put toggling 1,0,1,0.
  - Required: put sequence is header, w0, w1, header, w0, w1, with no gaps while RDY_put=1.
- Reset mid-message: assert sys_rst_pin during RX payload 2 of 4 and TX payload 1 of 3.
  - Required: EN outputs drop to 0 immediately; all outputs at their reset values.
  - Next RX word after release is treated as a header.

Source files
------------

// File: rtl/serial_msg_endpoint.sv
// Word-channel message endpoint: parses headered messages from the feeder's get port
// for a client, and frames client messages onto the feeder's put port.
module serial_msg_endpoint (
  input  logic        sys_clk_pin,
  input  logic        sys_rst_pin,
  input  logic        RDY_ppcMessageOutput_get,
  input  logic [31:0] ppcMessageOutput_get,
  output logic        EN_ppcMessageOutput_get,
  input  logic        RDY_ppcMessageInput_put,
  output logic [31:0] ppcMessageInput_put,
  output logic        EN_ppcMessageInput_put,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [31:0] rx_data,
  output logic [7:0]  rx_chan,
  output logic        rx_first,
  output logic        rx_last,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  input  logic [7:0]  tx_chan,
  input  logic [7:0]  tx_len,
  output logic        rx_err,
  output logic [15:0] rx_msg_count
);

  localparam logic [15:0] MAGIC = 16'hC0DE;

  typedef enum logic {R_HDR, R_PAY} rx_state_t;
  typedef enum logic {T_IDLE, T_PAY} tx_state_t;

  // A zero length field encodes a full 256-word message.
  function automatic logic [8:0] len_words(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

  // ---------------- receive path ----------------
  rx_state_t  rx_state;
  logic [8:0] rx_rem;
  logic [7:0] cur_chan;
  logic       first_pend;
  logic       rx_take;
  logic       rx_drain;
  logic       hdr_ok;

  assign hdr_ok   = (ppcMessageOutput_get[31:16] == MAGIC);
  assign rx_drain = rx_valid && rx_ready;

  // NOTE: assign a default first so every path drives rx_take and no latch is inferred.
  always_comb begin
    rx_take = 1'b0;
    if (!sys_rst_pin) begin
      if (rx_state == R_HDR) rx_take = RDY_ppcMessageOutput_get;
      else                   rx_take = RDY_ppcMessageOutput_get && (!rx_valid || rx_ready);
    end
  end

  assign EN_ppcMessageOutput_get = rx_take;

  always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
    if (sys_rst_pin) begin
      rx_state     <= R_HDR;
      rx_rem       <= '0;
      cur_chan     <= '0;
      first_pend   <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_chan      <= '0;
      rx_first     <= 1'b0;
      rx_last      <= 1'b0;
      rx_err       <= 1'b0;
      rx_msg_count <= '0;
    end else begin
      // NOTE: non-blocking updates; a load later in this block overrides this drain clear.
      if (rx_drain) begin
        rx_valid <= 1'b0;
        rx_first <= 1'b0;
        rx_last  <= 1'b0;
        rx_data  <= '0;
      end
      case (rx_state)
        R_HDR: begin
          if (rx_take) begin
            if (hdr_ok) begin
              cur_chan   <= ppcMessageOutput_get[15:8];
              rx_rem     <= len_words(ppcMessageOutput_get[7:0]);
              first_pend <= 1'b1;
              rx_state   <= R_PAY;
            end else begin
              rx_err <= 1'b1;
            end
          end
        end
        R_PAY: begin
          if (rx_take) begin
            rx_valid   <= 1'b1;
            rx_data    <= ppcMessageOutput_get;
            rx_chan    <= cur_chan;
            rx_first   <= first_pend;
            rx_last    <= (rx_rem == 9'd1);
            first_pend <= 1'b0;
            rx_rem     <= rx_rem - 9'd1;
            if (rx_rem == 9'd1) begin
              rx_state     <= R_HDR;
              rx_msg_count <= rx_msg_count + 16'd1;
            end
          end
        end
        default: rx_state <= R_HDR;
      endcase
    end
  end

  // ---------------- transmit path ----------------
  tx_state_t  tx_state;
  logic [8:0] tx_rem;
  logic       obuf_v;
  logic [31:0] obuf;
  logic       free;
  logic       put_fire;
  logic       tx_load;

  // obuf can take a new word whenever it is empty or being drained this cycle.
  assign free     = !obuf_v || RDY_ppcMessageInput_put;
  assign put_fire = obuf_v && RDY_ppcMessageInput_put;
  assign tx_load  = tx_valid && free;

  assign EN_ppcMessageInput_put = put_fire && !sys_rst_pin;
  assign ppcMessageInput_put    = obuf;
  assign tx_ready               = (tx_state == T_PAY) && free;

  always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
    if (sys_rst_pin) begin
      tx_state <= T_IDLE;
      tx_rem   <= '0;
      obuf_v   <= 1'b0;
      obuf     <= '0;
    end else begin
      if (put_fire) obuf_v <= 1'b0;
      if (tx_load) begin
        obuf_v <= 1'b1;
        if (tx_state == T_IDLE) begin
          obuf     <= {MAGIC, tx_chan, tx_len};
          tx_rem   <= len_words(tx_len);
          tx_state <= T_PAY;
        end else begin
          obuf   <= tx_data;
          tx_rem <= tx_rem - 9'd1;
          if (tx_rem == 9'd1) tx_state <= T_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_msg_endpoint.sv
// Bench for serial_msg_endpoint: message-level scoreboard for both directions plus
// directed scenarios with hand-computed expectations.
module tb_serial_msg_endpoint;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy_get;
  logic [31:0] get_word;
  logic        en_get;
  logic        rdy_put;
  logic [31:0] put_word;
  logic        en_put;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic [7:0]  rx_chan;
  logic        rx_first;
  logic        rx_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [7:0]  tx_chan;
  logic [7:0]  tx_len;
  logic        rx_err;
  logic [15:0] rx_msg_count;

  always #5 clk = ~clk;

  serial_msg_endpoint dut (
    .sys_clk_pin              (clk),
    .sys_rst_pin              (rst),
    .RDY_ppcMessageOutput_get (rdy_get),
    .ppcMessageOutput_get     (get_word),
    .EN_ppcMessageOutput_get  (en_get),
    .RDY_ppcMessageInput_put  (rdy_put),
    .ppcMessageInput_put      (put_word),
    .EN_ppcMessageInput_put   (en_put),
    .rx_valid                 (rx_valid),
    .rx_ready                 (rx_ready),
    .rx_data                  (rx_data),
    .rx_chan                  (rx_chan),
    .rx_first                 (rx_first),
    .rx_last                  (rx_last),
    .tx_valid                 (tx_valid),
    .tx_ready                 (tx_ready),
    .tx_data                  (tx_data),
    .tx_chan                  (tx_chan),
    .tx_len                   (tx_len),
    .rx_err                   (rx_err),
    .rx_msg_count             (rx_msg_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  chan;
    logic        first;
    logic        last;
  } rx_item_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  chan;
    logic [7:0]  len;
  } tx_item_t;

  logic [31:0] feed_q[$];
  rx_item_t    exp_rx[$];
  tx_item_t    tx_q[$];
  logic [31:0] exp_put[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit feed_en    = 1'b1;
  bit ready_ctl  = 1'b1;
  bit put_ctl    = 1'b1;
  bit put_toggle = 1'b0;

  int          en_get_cnt, deliv_cnt, first_cnt, last_cnt, lasts_total, put_cnt, gap_cnt;
  int          first_get_cyc, a_get_cyc, first_valid_cyc;
  logic [31:0] last_deliv, first_put;
  bit          put_started;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition not met (t=%0t)", name, $time);
  endtask

  task automatic clear_stats();
    en_get_cnt = 0; deliv_cnt = 0; first_cnt = 0; last_cnt = 0;
    put_cnt = 0; gap_cnt = 0; put_started = 1'b0;
    first_get_cyc = -1; a_get_cyc = -1; first_valid_cyc = -1;
    last_deliv = '0; first_put = '0;
  endtask

  // Expected client view of one RX message: payload words base, base+1, ...
  task automatic send_rx(input logic [7:0] chan, input int n, input logic [31:0] base);
    rx_item_t e;
    feed_q.push_back({16'hC0DE, chan, 8'(n)});
    for (int i = 0; i < n; i++) begin
      e.data  = base + 32'(i);
      e.chan  = chan;
      e.first = (i == 0);
      e.last  = (i == n - 1);
      exp_rx.push_back(e);
      feed_q.push_back(base + 32'(i));
    end
  endtask

  // Expected put stream of one TX message: header then payload in order.
  task automatic send_tx(input logic [7:0] chan, input int n, input logic [31:0] base);
    tx_item_t t;
    exp_put.push_back({16'hC0DE, chan, 8'(n)});
    for (int i = 0; i < n; i++) begin
      t.data = base + 32'(i);
      t.chan = chan;
      t.len  = 8'(n);
      tx_q.push_back(t);
      exp_put.push_back(base + 32'(i));
    end
  endtask

  function automatic bit busy();
    return (feed_q.size() != 0) || (exp_rx.size() != 0) ||
           (tx_q.size() != 0) || (exp_put.size() != 0);
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy()) fail_now(name);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Per-cycle observation, just after inputs settle and well before the next edge.
  task automatic sample();
    rx_item_t e;
    if (en_get) begin
      en_get_cnt++;
      if (first_get_cyc < 0) first_get_cyc = cyc;
      else if (a_get_cyc < 0) a_get_cyc = cyc;
      void'(feed_q.pop_front());
    end
    if (rx_valid && rx_ready) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      deliv_cnt++;
      if (rx_first) first_cnt++;
      if (rx_last) last_cnt++;
      last_deliv = rx_data;
      if (exp_rx.size() == 0) begin
        fail_now("rx_unexpected_word");
      end else begin
        e = exp_rx.pop_front();
        check("rx_data",  64'(rx_data),  64'(e.data));
        check("rx_chan",  64'(rx_chan),  64'(e.chan));
        check("rx_first", 64'(rx_first), 64'(e.first));
        check("rx_last",  64'(rx_last),  64'(e.last));
        if (e.last) begin
          lasts_total++;
          check("rx_msg_count", 64'(rx_msg_count), 64'(lasts_total));
        end
      end
    end
    if (en_put) begin
      put_started = 1'b1;
      put_cnt++;
      if (put_cnt == 1) first_put = put_word;
      if (exp_put.size() == 0) fail_now("put_unexpected_word");
      else check("put_word", 64'(put_word), 64'(exp_put.pop_front()));
    end else if (rdy_put && put_started && exp_put.size() != 0) begin
      gap_cnt++;
    end
    if (tx_valid && tx_ready) void'(tx_q.pop_front());
  endtask

  // Feeder and client models: drive on the falling edge, observe 1 time unit later.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rdy_get  = feed_en && (feed_q.size() != 0);
      get_word = rdy_get ? feed_q[0] : 32'h0;
      rx_ready = ready_ctl;
      rdy_put  = put_toggle ? (cyc % 2 == 1) : put_ctl;
      tx_valid = (tx_q.size() != 0);
      tx_data  = tx_valid ? tx_q[0].data : 32'h0;
      tx_chan  = tx_valid ? tx_q[0].chan : 8'h0;
      tx_len   = tx_valid ? tx_q[0].len  : 8'h0;
      #1;
      if (!rst) sample();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int snap;
    rdy_get = 1'b0; get_word = '0; rdy_put = 1'b0; rx_ready = 1'b0;
    tx_valid = 1'b0; tx_data = '0; tx_chan = '0; tx_len = '0;
    clear_stats();
    lasts_total = 0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("reset_en_get",   64'(en_get),       64'(0));
    check("reset_en_put",   64'(en_put),       64'(0));
    check("reset_rx_valid", 64'(rx_valid),     64'(0));
    check("reset_rx_count", 64'(rx_msg_count), 64'(0));
    check("reset_rx_err",   64'(rx_err),       64'(0));
    check("reset_tx_ready", 64'(tx_ready),     64'(0));
    check("reset_put_word", 64'(put_word),     64'(0));
    #20 rst = 1'b0;
    @(posedge clk); #1;

    // RX basic: C0DE_0503, A, B, C
    clear_stats();
    send_rx(8'd5, 3, 32'h0000_000A);
    wait_idle("rx_basic_timeout", 50);
    check("rx_basic_words",   64'(deliv_cnt), 64'(3));
    check("rx_basic_firsts",  64'(first_cnt), 64'(1));
    check("rx_basic_lasts",   64'(last_cnt),  64'(1));
    check("rx_basic_last_c",  64'(last_deliv), 64'(32'h0000_000C));
    check("rx_basic_count",   64'(rx_msg_count), 64'(1));
    check("rx_basic_chan",    64'(rx_chan), 64'(8'd5));
    check("rx_basic_hdr_gap", 64'(a_get_cyc - first_get_cyc), 64'(1));
    check("rx_basic_latency", 64'(first_valid_cyc - a_get_cyc), 64'(1));
    check("rx_basic_drained", 64'(rx_valid), 64'(0));

    // RX bad magic: 1234_0102 dropped, then C0DE_0101, D
    clear_stats();
    feed_q.push_back(32'h1234_0102);
    send_rx(8'd1, 1, 32'h0000_000D);
    wait_idle("rx_bad_timeout", 50);
    check("rx_bad_err",    64'(rx_err),     64'(1));
    check("rx_bad_words",  64'(deliv_cnt),  64'(1));
    check("rx_bad_data",   64'(last_deliv), 64'(32'h0000_000D));
    check("rx_bad_firsts", 64'(first_cnt),  64'(1));
    check("rx_bad_lasts",  64'(last_cnt),   64'(1));
    check("rx_bad_count",  64'(rx_msg_count), 64'(2));

    // RX backpressure: client stalls 5 cycles mid-message
    clear_stats();
    send_rx(8'd3, 8, 32'h0000_0100);
    n = 0;
    while (deliv_cnt < 2 && n < 50) begin @(posedge clk); #1; n++; end
    if (deliv_cnt < 2) fail_now("rx_bp_start_timeout");
    ready_ctl = 1'b0;
    snap = en_get_cnt;
    repeat (5) begin @(posedge clk); #1; end
    check("rx_bp_no_get",  64'(en_get_cnt - snap), 64'(0));
    check("rx_bp_holding", 64'(rx_valid), 64'(1));
    ready_ctl = 1'b1;
    wait_idle("rx_bp_timeout", 50);
    check("rx_bp_words", 64'(deliv_cnt), 64'(8));

    // TX 256-word message on channel 7
    clear_stats();
    send_tx(8'd7, 256, 32'h0000_1000);
    wait_idle("tx_256_timeout", 600);
    check("tx_256_header",   64'(first_put), 64'(32'hC0DE_0700));
    check("tx_256_puts",     64'(put_cnt),   64'(257));
    check("tx_256_gaps",     64'(gap_cnt),   64'(0));
    check("tx_256_idle_rdy", 64'(tx_ready),  64'(0));

    // TX back-to-back 2-word messages with RDY_put alternating
    clear_stats();
    put_toggle = 1'b1;
    send_tx(8'd2, 2, 32'h0000_2000);
    send_tx(8'd4, 2, 32'h0000_3000);
    wait_idle("tx_b2b_timeout", 100);
    check("tx_b2b_header", 64'(first_put), 64'(32'hC0DE_0202));
    check("tx_b2b_puts",   64'(put_cnt),   64'(6));
    check("tx_b2b_gaps",   64'(gap_cnt),   64'(0));
    put_toggle = 1'b0;

    // Reset mid-message: RX payload 2 of 4 held, TX payload 1 of 3 in obuf
    clear_stats();
    send_rx(8'd6, 4, 32'h0000_0400);
    @(posedge clk); #1;
    send_tx(8'd8, 3, 32'h0000_0500);
    n = 0;
    while (deliv_cnt < 1 && n < 50) begin @(posedge clk); #1; n++; end
    if (deliv_cnt < 1) fail_now("rst_mid_start_timeout");
    rst = 1'b1;
    #1;
    check("rst_mid_en_get",   64'(en_get),       64'(0));
    check("rst_mid_en_put",   64'(en_put),       64'(0));
    check("rst_mid_rx_valid", 64'(rx_valid),     64'(0));
    check("rst_mid_rx_first", 64'(rx_first),     64'(0));
    check("rst_mid_rx_last",  64'(rx_last),      64'(0));
    check("rst_mid_rx_data",  64'(rx_data),      64'(0));
    check("rst_mid_rx_chan",  64'(rx_chan),      64'(0));
    check("rst_mid_rx_err",   64'(rx_err),       64'(0));
    check("rst_mid_count",    64'(rx_msg_count), 64'(0));
    check("rst_mid_tx_ready", 64'(tx_ready),     64'(0));
    check("rst_mid_put_word", 64'(put_word),     64'(0));
    feed_q.delete(); exp_rx.delete(); tx_q.delete(); exp_put.delete();
    lasts_total = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    clear_stats();
    feed_q.push_back(32'h0000_0402);
    send_rx(8'd9, 1, 32'h0000_0055);
    wait_idle("rst_after_timeout", 50);
    check("rst_after_err",   64'(rx_err),       64'(1));
    check("rst_after_words", 64'(deliv_cnt),    64'(1));
    check("rst_after_data",  64'(last_deliv),   64'(32'h0000_0055));
    check("rst_after_count", 64'(rx_msg_count), 64'(1));
    check("rst_after_puts",  64'(put_cnt),      64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
